// File: rtl/sd_pkg.sv
// Shared SD command-path types: field widths, arbiter FSM encoding, request-slot record.
package sd_pkg;

    localparam int CMD_W = 6;
    localparam int ARG_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } sd_state_e;

    typedef struct packed {
        logic [CMD_W-1:0] cmd;
        logic [ARG_W-1:0] arg;
        logic             sta40;
        logic             readit;
        logic             init;
    } sd_slot_t;

endpackage

// File: rtl/sdcmd_slot.sv
// Per-requester capture register: latches a command on an accepted start pulse, holds it
// pending until the arbiter clears it, and flags (one cycle later) starts that arrive while busy.
module sdcmd_slot
    import sd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [CMD_W-1:0] cmd_i,
    input  logic [ARG_W-1:0] arg_i,
    input  logic             sta_i,
    input  logic             sta40_i,
    input  logic             readit_i,
    input  logic             init_i,
    input  logic             busy_i,
    input  logic             clr_i,
    output sd_slot_t         slot_o,
    output logic             pend_o,
    output logic             drop_o
);

    sd_slot_t slot_q, slot_d;
    logic     pend_q, pend_d;
    logic     drop_q, drop_d;
    logic     start;

    always_comb begin
        start  = sta_i | sta40_i;
        slot_d = slot_q;
        pend_d = pend_q;
        drop_d = 1'b0;
        // clr only ever arrives while pending (hence busy), so it never races a capture
        if (clr_i) begin
            pend_d = 1'b0;
        end
        if (start) begin
            if (busy_i) begin
                drop_d = 1'b1;
            end else begin
                slot_d.cmd    = cmd_i;
                slot_d.arg    = arg_i;
                slot_d.sta40  = sta40_i;
                slot_d.readit = readit_i;
                slot_d.init   = init_i;
                pend_d        = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= '0;
            pend_q <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            slot_q <= slot_d;
            pend_q <= pend_d;
            drop_q <= drop_d;
        end
    end

    assign slot_o = slot_q;
    assign pend_o = pend_q;
    assign drop_o = drop_q;

endmodule

// File: rtl/sdcmd_arbiter.sv
// Round-robin owner of the single SD command path between the card initializer (port 0) and
// the host disk manager (port 1); ownership is held until dev_rdy or the WAIT timeout fires.
module sdcmd_arbiter
    import sd_pkg::*;
#(
    parameter int unsigned TO_W    = 16,
    parameter int unsigned TIMEOUT = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CMD_W-1:0] rq_cmd_0,
    input  logic [CMD_W-1:0] rq_cmd_1,
    input  logic [ARG_W-1:0] rq_arg_0,
    input  logic [ARG_W-1:0] rq_arg_1,
    input  logic             rq_sta_0,
    input  logic             rq_sta_1,
    input  logic             rq_sta40_0,
    input  logic             rq_sta40_1,
    input  logic             rq_readit_0,
    input  logic             rq_readit_1,
    input  logic             rq_init_0,
    input  logic             rq_init_1,
    output logic             rq_busy_0,
    output logic             rq_busy_1,
    output logic             rq_done_0,
    output logic             rq_done_1,
    output logic             rq_err_0,
    output logic             rq_err_1,
    output logic [CMD_W-1:0] out_cmd,
    output logic [ARG_W-1:0] out_arg,
    output logic             out_readit,
    output logic             out_init,
    output logic             out_sta,
    output logic             out_sta40,
    input  logic             dev_rdy,
    output logic             owner,
    output logic             active
);

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);
    localparam bit              TO_EN  = (TIMEOUT != 0);

    sd_state_e       state_q, state_d;
    sd_slot_t        out_q, out_d;
    sd_slot_t        slot0, slot1;
    logic            own_q, own_d;
    logic            last_q, last_d;
    logic [TO_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0]      done_q, done_d;
    logic [1:0]      toerr_q, toerr_d;
    logic            pend0, pend1, drop0, drop1;
    logic [1:0]      pend, busy, clr;
    logic            gnt, fin;

    assign pend    = {pend1, pend0};
    assign active  = (state_q != IDLE);
    assign busy[0] = pend0 | (active & ~own_q);
    assign busy[1] = pend1 | (active & own_q);

    sdcmd_slot u_slot0 (
        .clk      (clk),
        .rst      (rst),
        .cmd_i    (rq_cmd_0),
        .arg_i    (rq_arg_0),
        .sta_i    (rq_sta_0),
        .sta40_i  (rq_sta40_0),
        .readit_i (rq_readit_0),
        .init_i   (rq_init_0),
        .busy_i   (busy[0]),
        .clr_i    (clr[0]),
        .slot_o   (slot0),
        .pend_o   (pend0),
        .drop_o   (drop0)
    );

    sdcmd_slot u_slot1 (
        .clk      (clk),
        .rst      (rst),
        .cmd_i    (rq_cmd_1),
        .arg_i    (rq_arg_1),
        .sta_i    (rq_sta_1),
        .sta40_i  (rq_sta40_1),
        .readit_i (rq_readit_1),
        .init_i   (rq_init_1),
        .busy_i   (busy[1]),
        .clr_i    (clr[1]),
        .slot_o   (slot1),
        .pend_o   (pend1),
        .drop_o   (drop1)
    );

    // On a tie the port that did not finish last wins
    assign gnt     = (pend0 & pend1) ? ~last_q : pend1;
    assign cnt_inc = cnt_q + TO_W'(1);

    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        last_d  = last_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        done_d  = 2'b00;
        toerr_d = 2'b00;
        fin     = 1'b0;
        clr     = 2'b00;
        case (state_q)
            IDLE: begin
                if (|pend) begin
                    own_d   = gnt;
                    out_d   = gnt ? slot1 : slot0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_inc;
                end
                if (dev_rdy) begin
                    fin            = 1'b1;
                    done_d[own_q]  = 1'b1;
                end else if (TO_EN && (cnt_inc == TO_LIM)) begin
                    fin            = 1'b1;
                    toerr_d[own_q] = 1'b1;
                end
                if (fin) begin
                    clr[own_q] = 1'b1;
                    last_d     = own_q;
                    out_d      = '0;
                    state_d    = IDLE;
                end
            end
            default: begin
                out_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= '0;
            own_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            done_q  <= 2'b00;
            toerr_q <= 2'b00;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            own_q   <= own_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            toerr_q <= toerr_d;
        end
    end

    assign rq_busy_0  = busy[0];
    assign rq_busy_1  = busy[1];
    assign rq_done_0  = done_q[0];
    assign rq_done_1  = done_q[1];
    assign rq_err_0   = drop0 | toerr_q[0];
    assign rq_err_1   = drop1 | toerr_q[1];
    assign out_cmd    = out_q.cmd;
    assign out_arg    = out_q.arg;
    assign out_readit = out_q.readit;
    assign out_init   = out_q.init;
    assign out_sta    = (state_q == ISSUE) & ~out_q.sta40;
    assign out_sta40  = (state_q == ISSUE) & out_q.sta40;
    assign owner      = own_q;

endmodule

// File: tb/tb_sdcmd_arbiter.sv
// Three arbiters (timeouts 20, 8, disabled) share one stimulus stream; each is compared every
// cycle with a transaction-level reference, plus directed checks on the key scenarios.
module tb_sdcmd_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  cmd [2];
    logic [31:0] arg [2];
    logic        sta [2];
    logic        s40 [2];
    logic        rdt [2];
    logic        ini [2];
    logic        dev_rdy;

    logic        bsy [3][2];
    logic        dn  [3][2];
    logic        er  [3][2];
    logic [5:0]  ocmd [3];
    logic [31:0] oarg [3];
    logic        ord [3], oini [3], osta [3], os40 [3], oown [3], oact [3];

    int TOV [3] = '{20, 8, 0};
    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sdcmd_arbiter #(
            .TO_W    (16),
            .TIMEOUT ((g == 0) ? 20 : ((g == 1) ? 8 : 0))
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .rq_cmd_0    (cmd[0]),
            .rq_cmd_1    (cmd[1]),
            .rq_arg_0    (arg[0]),
            .rq_arg_1    (arg[1]),
            .rq_sta_0    (sta[0]),
            .rq_sta_1    (sta[1]),
            .rq_sta40_0  (s40[0]),
            .rq_sta40_1  (s40[1]),
            .rq_readit_0 (rdt[0]),
            .rq_readit_1 (rdt[1]),
            .rq_init_0   (ini[0]),
            .rq_init_1   (ini[1]),
            .rq_busy_0   (bsy[g][0]),
            .rq_busy_1   (bsy[g][1]),
            .rq_done_0   (dn[g][0]),
            .rq_done_1   (dn[g][1]),
            .rq_err_0    (er[g][0]),
            .rq_err_1    (er[g][1]),
            .out_cmd     (ocmd[g]),
            .out_arg     (oarg[g]),
            .out_readit  (ord[g]),
            .out_init    (oini[g]),
            .out_sta     (osta[g]),
            .out_sta40   (os40[g]),
            .dev_rdy     (dev_rdy),
            .owner       (oown[g]),
            .active      (oact[g])
        );
    end

    // Reference: owner index (-1 = nobody), cycles since grant, WAIT cycles elapsed,
    // request queue per port, and the pulses expected in the current cycle.
    int          m_own [3], m_age [3], m_wait [3], m_last [3], m_ownr [3];
    bit          m_pend [3][2], m_done [3][2], m_err [3][2];
    logic [5:0]  m_cmd [3][2];
    logic [31:0] m_arg [3][2];
    bit          m_s40 [3][2], m_rd [3][2], m_ini [3][2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset(input int i);
        m_own[i]  = -1;
        m_age[i]  = 0;
        m_wait[i] = 0;
        m_last[i] = 1;
        m_ownr[i] = 0;
        for (int r = 0; r < 2; r++) begin
            m_pend[i][r] = 1'b0;
            m_done[i][r] = 1'b0;
            m_err[i][r]  = 1'b0;
        end
    endtask

    task automatic model_end(input int i, input bit ok);
        int o;
        o = m_own[i];
        if (ok) m_done[i][o] = 1'b1;
        else    m_err[i][o]  = 1'b1;
        m_pend[i][o] = 1'b0;
        m_last[i]    = o;
        m_own[i]     = -1;
    endtask

    task automatic model_step(input int i);
        bit p [2];
        int g;
        p[0] = m_pend[i][0];
        p[1] = m_pend[i][1];
        m_done[i][0] = 1'b0; m_done[i][1] = 1'b0;
        m_err[i][0]  = 1'b0; m_err[i][1]  = 1'b0;
        if (rst) begin
            model_reset(i);
            return;
        end
        if (m_own[i] < 0) begin
            g = -1;
            if (p[0] && p[1]) g = 1 - m_last[i];
            else if (p[0])    g = 0;
            else if (p[1])    g = 1;
            if (g >= 0) begin
                m_own[i]  = g;
                m_ownr[i] = g;
                m_age[i]  = 0;
            end
        end else if (m_age[i] == 0) begin
            m_age[i]  = 1;
            m_wait[i] = 0;
        end else if (dev_rdy) begin
            model_end(i, 1'b1);
        end else begin
            m_wait[i]++;
            if (TOV[i] != 0 && m_wait[i] == TOV[i]) model_end(i, 1'b0);
        end
        for (int r = 0; r < 2; r++) begin
            if (sta[r] || s40[r]) begin
                if (p[r]) begin
                    m_err[i][r] = 1'b1;
                end else begin
                    m_pend[i][r] = 1'b1;
                    m_cmd[i][r]  = cmd[r];
                    m_arg[i][r]  = arg[r];
                    m_s40[i][r]  = s40[r];
                    m_rd[i][r]   = rdt[r];
                    m_ini[i][r]  = ini[r];
                end
            end
        end
    endtask

    task automatic check_model(input int i);
        bit act, iss;
        int o;
        act = (m_own[i] >= 0);
        o   = act ? m_own[i] : 0;
        iss = act && (m_age[i] == 0);
        chk($sformatf("d%0d_cmd", i),    ocmd[i], act ? m_cmd[i][o] : 6'd0);
        chk($sformatf("d%0d_arg", i),    oarg[i], act ? m_arg[i][o] : 32'd0);
        chk($sformatf("d%0d_readit", i), ord[i],  act && m_rd[i][o]);
        chk($sformatf("d%0d_init", i),   oini[i], act && m_ini[i][o]);
        chk($sformatf("d%0d_sta", i),    osta[i], iss && !m_s40[i][o]);
        chk($sformatf("d%0d_sta40", i),  os40[i], iss && m_s40[i][o]);
        chk($sformatf("d%0d_active", i), oact[i], act);
        chk($sformatf("d%0d_owner", i),  oown[i], m_ownr[i][0]);
        for (int r = 0; r < 2; r++) begin
            chk($sformatf("d%0d_busy%0d", i, r), bsy[i][r], m_pend[i][r]);
            chk($sformatf("d%0d_done%0d", i, r), dn[i][r],  m_done[i][r]);
            chk($sformatf("d%0d_err%0d", i, r),  er[i][r],  m_err[i][r]);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        if (chk_en) for (int i = 0; i < 3; i++) check_model(i);
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i);
        #1;
        sta[0] = 1'b0; sta[1] = 1'b0;
        s40[0] = 1'b0; s40[1] = 1'b0;
        dev_rdy = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        dev_rdy = 1'b0;
        for (int r = 0; r < 2; r++) begin
            cmd[r] = '0; arg[r] = '0; sta[r] = 1'b0; s40[r] = 1'b0; rdt[r] = 1'b0; ini[r] = 1'b0;
        end
        for (int i = 0; i < 3; i++) model_reset(i);
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i);
        #1;
        chk_en = 1'b1;
        do_reset();
        chk("rst_active", oact[0], 1'b0);
        chk("rst_owner", oown[0], 1'b0);
        chk("rst_busy1", bsy[0][1], 1'b0);

        // single request on port 1
        cmd[1] = 6'd17; arg[1] = 32'h0000_0200; rdt[1] = 1'b1; ini[1] = 1'b0; sta[1] = 1'b1;
        cyc();
        chk("t1_busy", bsy[0][1], 1'b1);
        chk("t1_sta_early", osta[0], 1'b0);
        cyc();
        chk("t1_sta", osta[0], 1'b1);
        chk("t1_cmd", ocmd[0], 6'd17);
        chk("t1_arg", oarg[0], 32'h200);
        chk("t1_readit", ord[0], 1'b1);
        chk("t1_owner", oown[0], 1'b1);
        rdt[1] = 1'b0;
        repeat (10) cyc();
        chk("t1_wait_sta", osta[0], 1'b0);
        chk("t1_wait_readit", ord[0], 1'b1);
        dev_rdy = 1'b1;
        cyc();
        chk("t1_done", dn[0][1], 1'b1);
        chk("t1_busy_low", bsy[0][1], 1'b0);
        chk("t1_idle", oact[0], 1'b0);
        cyc();
        chk("t1_done_pulse", dn[0][1], 1'b0);

        // tie after reset, then a tie after port 0 finished last
        do_reset();
        cmd[0] = 6'd0;  arg[0] = 32'h0;   rdt[0] = 1'b0; ini[0] = 1'b1;
        cmd[1] = 6'd17; arg[1] = 32'h400; rdt[1] = 1'b1; ini[1] = 1'b0;
        sta[0] = 1'b1; sta[1] = 1'b1;
        cyc();
        cyc();
        chk("t2_first_owner", oown[0], 1'b0);
        chk("t2_first_sta", osta[0], 1'b1);
        cyc();
        dev_rdy = 1'b1;
        cyc();
        chk("t2_done0", dn[0][0], 1'b1);
        chk("t2_gap_idle", oact[0], 1'b0);
        chk("t2_p1_waiting", bsy[0][1], 1'b1);
        cyc();
        chk("t2_second_owner", oown[0], 1'b1);
        chk("t2_second_cmd", ocmd[0], 6'd17);
        chk("t2_second_sta", osta[0], 1'b1);
        cyc();
        dev_rdy = 1'b1;
        cyc();
        chk("t2_done1", dn[0][1], 1'b1);
        sta[0] = 1'b1;
        cyc();
        cyc();
        chk("t2_solo_owner", oown[0], 1'b0);
        cyc();
        dev_rdy = 1'b1;
        cyc();
        sta[0] = 1'b1; sta[1] = 1'b1;
        cyc();
        cyc();
        chk("t2_tie2_owner", oown[0], 1'b1);

        // preamble start (sta and sta40 together: sta40 wins); dev_rdy in ISSUE ignored
        do_reset();
        cmd[0] = 6'd0; arg[0] = 32'h0; ini[0] = 1'b1; rdt[0] = 1'b0;
        sta[0] = 1'b1; s40[0] = 1'b1;
        cyc();
        cyc();
        chk("t3_sta40", os40[0], 1'b1);
        chk("t3_sta", osta[0], 1'b0);
        chk("t3_init", oini[0], 1'b1);
        ini[0] = 1'b0;
        dev_rdy = 1'b1;
        cyc();
        chk("t3_stale_rdy_active", oact[0], 1'b1);
        chk("t3_stale_rdy_done", dn[0][0], 1'b0);
        repeat (4) begin
            cyc();
            chk("t3_wait_init", oini[0], 1'b1);
            chk("t3_wait_sta40", os40[0], 1'b0);
        end
        dev_rdy = 1'b1;
        cyc();
        chk("t3_done", dn[0][0], 1'b1);

        // drop while busy, then completion racing a same-port start
        do_reset();
        cmd[1] = 6'd24; arg[1] = 32'h1234; rdt[1] = 1'b0; ini[1] = 1'b0; sta[1] = 1'b1;
        cyc();
        chk("t4_busy", bsy[0][1], 1'b1);
        cmd[1] = 6'd25; arg[1] = 32'hdead; sta[1] = 1'b1;
        cyc();
        chk("t4_drop_err", er[0][1], 1'b1);
        chk("t4_cmd_kept", ocmd[0], 6'd24);
        chk("t4_arg_kept", oarg[0], 32'h1234);
        cyc();
        chk("t4_err_pulse", er[0][1], 1'b0);
        dev_rdy = 1'b1; sta[1] = 1'b1;
        cyc();
        chk("t4_race_done", dn[0][1], 1'b1);
        chk("t4_race_err", er[0][1], 1'b1);
        chk("t4_race_busy", bsy[0][1], 1'b0);

        // timeout (instance 1: 8 cycles) and disabled timeout (instance 2)
        do_reset();
        cmd[0] = 6'd5; arg[0] = 32'h1; sta[0] = 1'b1;
        cyc();
        cmd[1] = 6'd9; sta[1] = 1'b1;
        cyc();
        repeat (8) cyc();
        chk("t5_to8_still", oact[1], 1'b1);
        chk("t5_to8_noerr", er[1][0], 1'b0);
        cyc();
        chk("t5_to8_err", er[1][0], 1'b1);
        chk("t5_to8_idle", oact[1], 1'b0);
        chk("t5_to8_busy0", bsy[1][0], 1'b0);
        cyc();
        chk("t5_next_sta", osta[1], 1'b1);
        chk("t5_next_owner", oown[1], 1'b1);
        chk("t5_next_cmd", ocmd[1], 6'd9);
        repeat (40) cyc();
        chk("t5_to0_active", oact[2], 1'b1);
        chk("t5_to0_owner", oown[2], 1'b0);
        chk("t5_to0_noerr", er[2][0], 1'b0);

        // reset while instance 2 is still stuck in WAIT
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t6_active", oact[2], 1'b0);
        chk("t6_cmd", ocmd[2], 6'd0);
        chk("t6_done0", dn[2][0], 1'b0);
        chk("t6_err0", er[2][0], 1'b0);
        chk("t6_busy1", bsy[2][1], 1'b0);
        sta[0] = 1'b1; sta[1] = 1'b1;
        cyc();
        cyc();
        chk("t6_first_owner", oown[2], 1'b0);
        chk("t6_first_sta", osta[2], 1'b1);

        // random traffic with occasional resets
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int r = 0; r < 2; r++) begin
                cmd[r] = 6'($urandom);
                arg[r] = $urandom;
                rdt[r] = 1'($urandom_range(0, 1));
                ini[r] = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 5) == 0) begin
                    case ($urandom_range(0, 2))
                        0:       sta[r] = 1'b1;
                        1:       s40[r] = 1'b1;
                        default: begin sta[r] = 1'b1; s40[r] = 1'b1; end
                    endcase
                end
            end
            dev_rdy = ($urandom_range(0, 9) == 0);
            rst     = ($urandom_range(0, 399) == 0);
            cyc();
        end
        rst = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
